option_fifo: RTL and testbench

- Parametrised FIFO whose read side is a Spade-encoded `Option<int<W>>` rather than a separate data/valid pair.
- Successor to the single-cycle Option instantiation block. Adds configurable payload width and depth, buffering, and overflow/underflow reporting.
- Sits between a producer that pushes raw payloads and a consumer that pattern-matches on the Option tag.
- Encoding is fixed: variant 0 = Some, variant 1 = None. The tag occupies the MSB of the packed value.

---
 rtl/option_pkg.sv | 31 +++
 rtl/option_pack.sv | 18 +
 rtl/option_fifo.sv | 93 +++++++++
 tb/tb_option_fifo.sv | 127 ++++++++++++
 4 files changed

// File: rtl/option_pkg.sv
// Shared encoding of Spade Option<int<W>>: tag in the MSB, 0 = Some, 1 = None.
package option_pkg;

    localparam logic TAG_SOME = 1'b0;
    localparam logic TAG_NONE = 1'b1;

    // Widest payload the packing helpers handle; callers slice the low w+1 bits.
    localparam int MAX_W = 64;

    function automatic int option_width(input int w);
        return w + 1;
    endfunction

    function automatic logic [MAX_W:0] mk_some(input logic [MAX_W-1:0] payload, input int w);
        logic [MAX_W:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) r[i] = payload[i];
        end
        r[w] = TAG_SOME;
        return r;
    endfunction

    function automatic logic [MAX_W:0] mk_none(input int w);
        logic [MAX_W:0] r;
        r    = '0;
        r[w] = TAG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/option_pack.sv
// Packs a valid/payload pair into Option<int<W>>; None always carries a zero payload.
// Purely combinational, no backpressure.
module option_pack
    import option_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         valid_i,
    input  logic [W-1:0] payload_i,
    output logic [W:0]   opt_o
);

    always_comb begin
        opt_o = {TAG_NONE, {W{1'b0}}};
        if (valid_i) opt_o = {TAG_SOME, payload_i};
    end

endmodule

// File: rtl/option_fifo.sv
// First-word-fall-through FIFO presenting its head as Option<int<W>> (None when empty).
// Pushes to a full FIFO without a same-cycle pop are dropped and flagged; empty pops are flagged.
module option_fifo
    import option_pkg::*;
#(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [W-1:0]  x_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [W:0]    output__,
    output logic          full_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        do_pop  = pop_i && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push = push_i && (!full || do_pop);

        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        mem_d       = mem_q;
        count_d     = count_q + CW'(do_push) - CW'(do_pop);
        overflow_d  = overflow_q  || (push_i && !do_push);
        underflow_d = underflow_q || (pop_i && empty);

        if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push) begin
            mem_d[wr_ptr_q] = x_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; the count alone decides what is live.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    option_pack #(.W(W)) u_pack (
        .valid_i   (!empty),
        .payload_i (mem_q[rd_ptr_q]),
        .opt_o     (output__)
    );

    assign full_o      = full;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    tag_matches_count: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        output__[W] == (count_q == '0));

endmodule

// File: tb/tb_option_fifo.sv
// Directed bench for option_fifo (W=16, DEPTH=4) with a queue scoreboard model.
module tb_option_fifo;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] x_i = '0;
    logic        push_i = 1'b0;
    logic        pop_i = 1'b0;
    logic [16:0] output__;
    logic        full_o;
    logic [2:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;

    int checks = 0;
    int failures = 0;

    logic [15:0] sb_q [$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    option_fifo #(.W(16), .DEPTH(4)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .x_i         (x_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .output__    (output__),
        .full_o      (full_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [16:0] exp_out;
        exp_out = (sb_q.size() > 0) ? {1'b0, sb_q[0]} : 17'h10000;
        chk({tag, ".out"},   32'(output__),    32'(exp_out));
        chk({tag, ".count"}, 32'(count_o),     32'(sb_q.size()));
        chk({tag, ".full"},  32'(full_o),      32'(sb_q.size() == 4));
        chk({tag, ".ovf"},   32'(overflow_o),  32'(m_ovf));
        chk({tag, ".unf"},   32'(underflow_o), 32'(m_unf));
    endtask

    // One clock edge: drive inputs, update the model, sample #1 after the edge.
    task automatic step(input string tag, input logic rst, input logic psh,
                        input logic pp, input logic [15:0] x);
        logic m_pop;
        logic m_push;
        rst_n_i = ~rst;
        push_i  = psh;
        pop_i   = pp;
        x_i     = x;
        #1;
        if (rst) begin
            sb_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_pop  = pp && (sb_q.size() > 0);
            m_push = psh && ((sb_q.size() < 4) || m_pop);
            if (m_pop) begin
                chk({tag, ".pop_data"}, 32'(output__), 32'({1'b0, sb_q[0]}));
                void'(sb_q.pop_front());
            end
            if (pp && !m_pop) m_unf = 1'b1;
            if (psh && !m_push) m_ovf = 1'b1;
            if (m_push) sb_q.push_back(x);
        end
        @(posedge clk_i);
        #1;
        check_state(tag);
    endtask

    initial begin
        step("rst0", 1'b1, 1'b0, 1'b0, 16'h0);
        step("rst1", 1'b1, 1'b0, 1'b0, 16'h0);
        step("idle", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("idle_none", 32'(output__), 32'h10000);

        step("push123", 1'b0, 1'b1, 1'b0, 16'd123);
        chk("some123", 32'(output__), 32'h0007B);
        step("pop123", 1'b0, 1'b0, 1'b1, 16'h0);
        chk("none_after_pop", 32'(output__), 32'h10000);

        for (int i = 1; i <= 4; i++) step("fill", 1'b0, 1'b1, 1'b0, 16'(i));
        chk("full_flag", 32'(full_o), 32'd1);
        step("push5_drop", 1'b0, 1'b1, 1'b0, 16'd5);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("count_stays4", 32'(count_o), 32'd4);
        for (int i = 1; i <= 4; i++) step("drain", 1'b0, 1'b0, 1'b1, 16'h0);
        chk("drained_none", 32'(output__), 32'h10000);

        for (int i = 1; i <= 4; i++) step("refill", 1'b0, 1'b1, 1'b0, 16'(i));
        step("push9_pop", 1'b0, 1'b1, 1'b1, 16'd9);
        chk("head2", 32'(output__), 32'h00002);
        chk("count4_swap", 32'(count_o), 32'd4);
        for (int i = 0; i < 4; i++) step("drain9", 1'b0, 1'b0, 1'b1, 16'h0);

        step("pop_push_empty", 1'b0, 1'b1, 1'b1, 16'hBEEF);
        chk("beef_out", 32'(output__), 32'h0BEEF);
        chk("unf_set", 32'(underflow_o), 32'd1);
        step("pop_beef", 1'b0, 1'b0, 1'b1, 16'h0);

        step("clr", 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step("fill3", 1'b0, 1'b1, 1'b0, 16'(16'hA0 + i));
        step("rst_push", 1'b1, 1'b1, 1'b0, 16'hDEAD);
        chk("rst_none", 32'(output__), 32'h10000);
        chk("rst_count", 32'(count_o), 32'd0);
        step("push7", 1'b0, 1'b1, 1'b0, 16'd7);
        chk("some7", 32'(output__), 32'h00007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
